// File: rtl/bram_img_unpack.sv
// Streams a packed 1-bit image (32 px/word, MSB first) out of BRAM port B as a valid/ready pixel stream.
// Define UNPACK_PREFETCH_EN to double-buffer the next word and remove the inter-word gap.
module bram_img_unpack #(
  parameter logic [31:0] BASE_ADDR = 32'h4300_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] h,
  input  logic [10:0] w,
  output logic        clkb,
  output logic        rstb,
  output logic [31:0] addrb,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, FIN} state_t;

  state_t      state;
  logic [16:0] k;
  logic [16:0] words;
  logic [4:0]  rem;
  logic [31:0] sreg;
  logic [5:0]  bits_left;
  logic [7:0]  cnt;
  logic [21:0] total_c;
  logic [16:0] words_c;
  logic        more;

  assign clkb = clk;
  assign rstb = rst;
  assign web  = 4'd0;
  assign dinb = 32'd0;

  assign total_c = 22'(h) * 22'(w);
  assign words_c = 17'((23'(total_c) + 23'd31) >> 5);
  assign more    = (18'(k) + 18'd1) < 18'(words);

  function automatic logic [31:0] word_addr(input logic [16:0] idx);
    return BASE_ADDR + {13'd0, idx, 2'b00};
  endfunction

  // The last word may be partial; its unused low bits are never presented.
  function automatic logic [5:0] word_bits(input logic [16:0] idx, input logic [16:0] nwords,
                                           input logic [4:0] r);
    return (idx == nwords - 17'd1 && r != 5'd0) ? {1'b0, r} : 6'd32;
  endfunction

`ifdef UNPACK_PREFETCH_EN
  logic [31:0] hold;
  logic        pf_pend;
  logic [7:0]  pf_cnt;
  logic        pf_hit;
  logic        more2;
  logic [31:0] nxt_word;

  assign pf_hit   = pf_pend && (pf_cnt == 8'(RD_LAT));
  assign more2    = (18'(k) + 18'd2) < 18'(words);
  assign nxt_word = pf_hit ? doutb : hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrb     <= BASE_ADDR;
      enb       <= 1'b0;
      pix       <= 1'b0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
`ifdef UNPACK_PREFETCH_EN
      pf_pend   <= 1'b0;
      pf_cnt    <= '0;
`endif
    end else begin
`ifdef UNPACK_PREFETCH_EN
      // Capture the prefetched word once its read latency has elapsed.
      if (pf_pend) begin
        if (pf_hit) begin
          hold    <= doutb;
          pf_pend <= 1'b0;
        end else begin
          pf_cnt <= pf_cnt + 8'd1;
        end
      end
`endif
      case (state)
        IDLE: begin
          done      <= 1'b0;
          pix_valid <= 1'b0;
          if (start) begin
            k     <= '0;
            words <= words_c;
            rem   <= total_c[4:0];
            busy  <= 1'b1;
            if (total_c == 22'd0) begin
              state <= FIN;
            end else begin
              enb   <= 1'b1;
              addrb <= BASE_ADDR;
              state <= REQ;
            end
          end
        end
        REQ: begin
          enb   <= 1'b0;
          cnt   <= 8'd1;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 8'(RD_LAT)) begin
            sreg      <= doutb;
            pix       <= doutb[31];
            bits_left <= word_bits(k, words, rem);
            pix_valid <= 1'b1;
            state     <= SHIFT;
`ifdef UNPACK_PREFETCH_EN
            if (more) begin
              enb     <= 1'b1;
              addrb   <= word_addr(k + 17'd1);
              pf_pend <= 1'b1;
              pf_cnt  <= '0;
            end
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          enb <= 1'b0;
          if (pix_valid && pix_ready) begin
            if (bits_left == 6'd1) begin
              if (more) begin
`ifdef UNPACK_PREFETCH_EN
                sreg      <= nxt_word;
                pix       <= nxt_word[31];
                bits_left <= word_bits(k + 17'd1, words, rem);
                k         <= k + 17'd1;
                if (more2) begin
                  enb     <= 1'b1;
                  addrb   <= word_addr(k + 17'd2);
                  pf_pend <= 1'b1;
                  pf_cnt  <= '0;
                end
`else
                k         <= k + 17'd1;
                pix_valid <= 1'b0;
                enb       <= 1'b1;
                addrb     <= word_addr(k + 17'd1);
                state     <= REQ;
`endif
              end else begin
                pix_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                state     <= FIN;
              end
            end else begin
              sreg      <= {sreg[30:0], 1'b0};
              pix       <= sreg[30];
              bits_left <= bits_left - 6'd1;
            end
          end
        end
        FIN: begin
          // An empty frame arrives here with done still low and pulses it one cycle later.
          pix_valid <= 1'b0;
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_img_unpack.sv
// Directed self-checking bench for bram_img_unpack with a one-cycle-latency BRAM model.
module tb_bram_img_unpack;

  localparam logic [31:0] BASE = 32'h4300_0000;
`ifdef UNPACK_PREFETCH_EN
  localparam int EXP_GAP  = 0;
  localparam int EXP_ENB2 = 3;
`else
  localparam int EXP_GAP  = 2;
  localparam int EXP_ENB2 = 35;
`endif

  logic        clk = 1'b0;
  logic        rst, start, pix_ready;
  logic [10:0] h, w;
  logic        clkb, rstb, enb, pix, pix_valid, busy, done;
  logic [31:0] addrb, dinb, doutb;
  logic [3:0]  web;

  bram_img_unpack #(.BASE_ADDR(BASE), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .h(h), .w(w),
    .clkb(clkb), .rstb(rstb), .addrb(addrb), .enb(enb), .web(web), .dinb(dinb),
    .doutb(doutb), .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4];
  initial doutb = 32'd0;
  always @(posedge clk) if (enb) doutb <= mem[2'((addrb - BASE) >> 2)];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          n_enb, first_pv, last_acc, done_cyc, n_done, gaps, stall_bad, n_acc, max_run, enb2_cyc;
  logic [31:0] q_addr[$];
  bit          q_pix[$];

  function automatic logic [31:0] pack_bits(input int from, input int n);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r = {r[30:0], q_pix[from + i]};
    return r;
  endfunction

  // Cycle 0 is the start cycle; cycle i is observed at the negedge i cycles later.
  task automatic run_frame(input logic [10:0] hh, input logic [10:0] ww, input int mode,
                           input int busy_start_at, input int stop_at_acc);
    int  i = 0;
    int  run = 0;
    bit  prev_stall = 1'b0;
    bit  prev_pix = 1'b0;
    n_enb = 0; first_pv = -1; last_acc = -1; done_cyc = -1; n_done = 0;
    gaps = 0; stall_bad = 0; n_acc = 0; max_run = 0; enb2_cyc = -1;
    q_addr.delete(); q_pix.delete();
    @(negedge clk);
    start = 1'b1; h = hh; w = ww; pix_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      i++;
      start = (i == busy_start_at);
      h = 11'(i * 7); w = 11'(i * 3);
      pix_ready = (mode == 0) ? 1'b1 : (i % 2 == 1);
      if (prev_stall && (pix !== prev_pix || pix_valid !== 1'b1)) stall_bad++;
      prev_stall = pix_valid && !pix_ready;
      prev_pix = pix;
      if (enb) begin
        q_addr.push_back(addrb);
        n_enb++;
        if (n_enb == 2) enb2_cyc = i;
      end
      if (pix_valid) begin
        if (first_pv < 0) first_pv = i;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        if (first_pv >= 0 && busy) gaps++;
      end
      if (pix_valid && pix_ready) begin
        q_pix.push_back(pix);
        n_acc++;
        last_acc = i;
        if (n_acc == stop_at_acc) return;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
      if (done_cyc >= 0 && i >= done_cyc + 2) break;
      if (i >= 2000) begin
        check_eq("frame_timeout", 32'(done_cyc), 32'(i));
        break;
      end
    end
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; h = '0; w = '0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_addrb", addrb, BASE);
    check_eq("rst_enb", 32'(enb), 0);
    check_eq("rst_web", 32'(web), 0);
    check_eq("rst_dinb", dinb, 0);
    check_eq("rst_rstb", 32'(rstb), 1);
    check_eq("rst_pix", 32'({pix, pix_valid}), 0);
    check_eq("rst_busy_done", 32'({busy, done}), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstb_low", 32'(rstb), 0);

    // 4x8 single full word
    mem[0] = 32'hA5A5_0F0F;
    run_frame(11'd4, 11'd8, 0, -1, 0);
    check_eq("t1_enb_count", 32'(n_enb), 1);
    check_eq("t1_addr", q_addr[0], BASE);
    check_eq("t1_first_pv", 32'(first_pv), 3);
    check_eq("t1_accepts", 32'(n_acc), 32);
    check_eq("t1_pixels", pack_bits(0, 32), 32'hA5A5_0F0F);
    check_eq("t1_last_acc", 32'(last_acc), 34);
    check_eq("t1_done_cyc", 32'(done_cyc), 35);
    check_eq("t1_done_pulses", 32'(n_done), 1);
    check_eq("t1_busy_end", 32'(busy), 0);

    // 3x15 = 45 px over two words, partial last word
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h8000_0000;
    run_frame(11'd3, 11'd15, 0, -1, 0);
    check_eq("t2_enb_count", 32'(n_enb), 2);
    check_eq("t2_addr0", q_addr[0], BASE);
    check_eq("t2_addr1", q_addr[1], BASE + 32'd4);
    check_eq("t2_accepts", 32'(n_acc), 45);
    check_eq("t2_word0", pack_bits(0, 32), 32'hFFFF_FFFF);
    check_eq("t2_tail", pack_bits(32, 13), 32'h0000_1000);
    check_eq("t2_gap", 32'(gaps), 32'(EXP_GAP));
    check_eq("t2_enb2_cyc", 32'(enb2_cyc), 32'(EXP_ENB2));
    check_eq("t2_done_cyc", 32'(done_cyc), 32'(last_acc + 1));
    check_eq("t2_done_pulses", 32'(n_done), 1);

    // Backpressure: ready toggles every cycle
    mem[0] = 32'hA5A5_0F0F;
    run_frame(11'd4, 11'd8, 1, -1, 0);
    check_eq("t3_accepts", 32'(n_acc), 32);
    check_eq("t3_pixels", pack_bits(0, 32), 32'hA5A5_0F0F);
    check_eq("t3_stall_stable", 32'(stall_bad), 0);
    check_eq("t3_done_cyc", 32'(done_cyc), 32'(last_acc + 1));
    check_eq("t3_done_pulses", 32'(n_done), 1);

    // Empty frame
    run_frame(11'd0, 11'd100, 0, -1, 0);
    check_eq("t4_enb_count", 32'(n_enb), 0);
    check_eq("t4_no_pv", 32'(first_pv), 32'hFFFF_FFFF);
    check_eq("t4_done_cyc", 32'(done_cyc), 2);
    check_eq("t4_done_pulses", 32'(n_done), 1);

    // Reset after 10 accepts of the 45-pixel frame, start coincident with reset
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h8000_0000;
    run_frame(11'd3, 11'd15, 0, -1, 10);
    rst = 1'b1; start = 1'b1; h = 11'd3; w = 11'd15;
    @(negedge clk);
    check_eq("t5_rst_addrb", addrb, BASE);
    check_eq("t5_rst_enb", 32'(enb), 0);
    check_eq("t5_rst_rstb", 32'(rstb), 1);
    check_eq("t5_rst_pix", 32'({pix, pix_valid}), 0);
    check_eq("t5_rst_busy_done", 32'({busy, done}), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("t5_start_in_rst_ignored", 32'({busy, enb}), 0);
    run_frame(11'd3, 11'd15, 0, 10, 0);
    check_eq("t5_restart_addr", q_addr[0], BASE);
    check_eq("t5_enb_count", 32'(n_enb), 2);
    check_eq("t5_accepts", 32'(n_acc), 45);
    check_eq("t5_tail", pack_bits(32, 13), 32'h0000_1000);
    check_eq("t5_done_pulses", 32'(n_done), 1);

`ifdef UNPACK_PREFETCH_EN
    // 8x8 = two full words streamed without a gap
    mem[0] = 32'hF0F0_F0F0; mem[1] = 32'h0F0F_0F0F;
    run_frame(11'd8, 11'd8, 0, -1, 0);
    check_eq("pf_run", 32'(max_run), 64);
    check_eq("pf_enb2_cyc", 32'(enb2_cyc), 3);
    check_eq("pf_word0", pack_bits(0, 32), 32'hF0F0_F0F0);
    check_eq("pf_word1", pack_bits(32, 32), 32'h0F0F_0F0F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
